// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Receive-side parser for the rotary-counter UART frame. Hunts for the 0x5A
//   header, collects nine payload bytes, verifies the 8-bit additive checksum
//   and publishes three 24-bit rotary counts extended to BITS bits.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle byte strobe from the UART RX core
//   rx_error     framing/parity error; aborts a frame in progress
//   rot1_val     last good rotary 1 count
//   rot2_val     last good rotary 2 count
//   rot3_val     last good rotary 3 count
//   frame_valid  one-cycle pulse when rotN_val were updated
//   in_frame     high while collecting payload or waiting for the checksum
//   cs_err_cnt   saturating checksum-mismatch count
//   abort_cnt    saturating timeout / rx_error abort count
module uart_frame_parser #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned SIGN_EXT = 1,
    parameter int unsigned TIMEOUT  = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    input  logic            rx_error,
    output logic [BITS-1:0] rot1_val,
    output logic [BITS-1:0] rot2_val,
    output logic [BITS-1:0] rot3_val,
    output logic            frame_valid,
    output logic            in_frame,
    output logic [7:0]      cs_err_cnt,
    output logic [7:0]      abort_cnt
);

    localparam logic [7:0]  HEADER   = 8'h5A;
    localparam int unsigned PAY_W    = 72;
    localparam int unsigned IDX_W    = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(9);
    // Counter only needs to reach TIMEOUT-1; the abort fires on the edge that
    // would have taken it to TIMEOUT.
    localparam int unsigned TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        CS   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         acc_q, acc_d;
    logic [PAY_W-1:0]   pay_q, pay_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               load;
    logic               cs_fail;
    logic               abort;

    // Extend a 24-bit count to BITS, optionally replicating bit 23.
    function automatic logic [BITS-1:0] extend(input logic [23:0] v);
        logic [BITS-1:0] r;
        r       = (SIGN_EXT != 0 && v[23]) ? '1 : '0;
        r[23:0] = v;
        return r;
    endfunction

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        pay_d   = pay_q;
        to_d    = to_q;
        load    = 1'b0;
        cs_fail = 1'b0;
        abort   = 1'b0;

        case (state_q)
            HUNT: begin
                to_d = '0;
                // rx_error masks a coincident byte even while hunting.
                if (rx_valid && !rx_error && rx_data == HEADER) begin
                    state_d = DATA;
                    acc_d   = HEADER;
                    idx_d   = IDX_W'(1);
                end
            end

            DATA, CS: begin
                if (rx_error) begin
                    abort   = 1'b1;
                    state_d = HUNT;
                end else if (rx_valid) begin
                    // A byte always beats a coincident timeout.
                    to_d = '0;
                    if (state_q == DATA) begin
                        // Shift in from the top: byte 1 ends at pay[7:0].
                        pay_d = {rx_data, pay_q[PAY_W-1:8]};
                        acc_d = acc_q + rx_data;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = CS;
                        end
                    end else begin
                        if (rx_data == acc_q) begin
                            load = 1'b1;
                        end else begin
                            cs_fail = 1'b1;
                        end
                        state_d = HUNT;
                    end
                end else if (to_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = HUNT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end

                if (state_d == HUNT) begin
                    idx_d = '0;
                    acc_d = '0;
                    to_d  = '0;
                end
            end

            default: begin
                state_d = HUNT;
                idx_d   = '0;
                acc_d   = '0;
                to_d    = '0;
            end
        endcase
    end

    // FSM state and frame datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            idx_q   <= '0;
            acc_q   <= '0;
            pay_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pay_q   <= pay_d;
            to_q    <= to_d;
        end
    end

    // Published counts: all three load together from one verified frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot1_val    <= '0;
            rot2_val    <= '0;
            rot3_val    <= '0;
            frame_valid <= 1'b0;
            in_frame    <= 1'b0;
        end else begin
            frame_valid <= load;
            in_frame    <= (state_d != HUNT);
            if (load) begin
                rot1_val <= extend(pay_q[23:0]);
                rot2_val <= extend(pay_q[47:24]);
                rot3_val <= extend(pay_q[71:48]);
            end
        end
    end

    // Saturating error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_err_cnt <= '0;
            abort_cnt  <= '0;
        end else begin
            if (cs_fail && cs_err_cnt != 8'hFF) begin
                cs_err_cnt <= cs_err_cnt + 8'd1;
            end
            if (abort && abort_cnt != 8'hFF) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end

endmodule
